// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier between NUM_REQ requesters.
// Optional watchdog on the m_done wait is built when MULT_ARB_TIMEOUT_EN is defined.
module mult_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int A_WIDTH        = 9,
  parameter int B_WIDTH        = 9,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*A_WIDTH-1:0]   a_in,
  input  logic [NUM_REQ*B_WIDTH-1:0]   b_in,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [NUM_REQ-1:0]           done,
  output logic [A_WIDTH+B_WIDTH-1:0]   p_out,
  output logic                         err,
  output logic [A_WIDTH-1:0]           m_a,
  output logic [B_WIDTH-1:0]           m_b,
  output logic                         m_en,
  input  logic                         m_done,
  input  logic [A_WIDTH+B_WIDTH-1:0]   m_p
);

  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int P_WIDTH = A_WIDTH + B_WIDTH;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("mult_arbiter: unsupported parameter set");
  end

  state_t               state_reg, state_next;
  logic [NUM_REQ-1:0]   gnt_reg, gnt_next;
  logic [NUM_REQ-1:0]   done_reg, done_next;
  logic [P_WIDTH-1:0]   p_reg, p_next;
  logic [A_WIDTH-1:0]   ma_reg, ma_next;
  logic [B_WIDTH-1:0]   mb_reg, mb_next;
  logic                 men_reg, men_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [IDX_W-1:0]     ptr_reg, ptr_next;
  logic                 err_next;

  // Unpacked per-requester operand views
  logic [A_WIDTH-1:0] a_slice [NUM_REQ];
  logic [B_WIDTH-1:0] b_slice [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign a_slice[gi] = a_in[gi*A_WIDTH +: A_WIDTH];
    assign b_slice[gi] = b_in[gi*B_WIDTH +: B_WIDTH];
  end

  // Search upward from ptr+1, wrapping, for the first pending request
  logic [IDX_W-1:0] sel;
  logic             found;
  logic [IDX_W:0]   cand;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, ptr_reg} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!found && req[cand[IDX_W-1:0]]) begin
        sel   = cand[IDX_W-1:0];
        found = 1'b1;
      end
    end
  end

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             err_reg;
  logic             timeout;
  assign timeout = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    done_next  = '0;
    p_next     = p_reg;
    ma_next    = ma_reg;
    mb_next    = mb_reg;
    men_next   = 1'b0;
    idx_next   = idx_reg;
    ptr_next   = ptr_reg;
    err_next   = 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
    cnt_next   = cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (found) begin
          gnt_next   = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel;
          idx_next   = sel;
          ma_next    = a_slice[sel];
          mb_next    = b_slice[sel];
          men_next   = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        state_next = WAIT;
`ifdef MULT_ARB_TIMEOUT_EN
        cnt_next   = '0;
`endif
      end
      WAIT: begin
        if (m_done) begin
          p_next     = m_p;
          done_next  = gnt_reg;
          state_next = RESP;
        end
`ifdef MULT_ARB_TIMEOUT_EN
        else if (timeout) begin
          err_next   = 1'b1;
          done_next  = gnt_reg;
          state_next = RESP;
        end
        if (cnt_reg != CNT_W'(TIMEOUT_CYCLES)) cnt_next = cnt_reg + 1'b1;
`endif
      end
      RESP: begin
        gnt_next   = '0;
        ptr_next   = idx_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      done_reg  <= '0;
      p_reg     <= '0;
      ma_reg    <= '0;
      mb_reg    <= '0;
      men_reg   <= 1'b0;
      idx_reg   <= '0;
      ptr_reg   <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      done_reg  <= done_next;
      p_reg     <= p_next;
      ma_reg    <= ma_next;
      mb_reg    <= mb_next;
      men_reg   <= men_next;
      idx_reg   <= idx_next;
      ptr_reg   <= ptr_next;
    end
  end

`ifdef MULT_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      err_reg <= err_next;
    end
  end
  assign err = err_reg;
`else
  logic unused_err;
  assign unused_err = err_next;
  assign err        = 1'b0;
`endif

  assign gnt   = gnt_reg;
  assign done  = done_reg;
  assign p_out = p_reg;
  assign m_a   = ma_reg;
  assign m_b   = mb_reg;
  assign m_en  = men_reg;

endmodule
